// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
// Shared types and helpers for the configuration-chain loader.
//   cfg_state_t  : loader FSM states (IDLE, LOAD, VERIFY, DONE)
//   CFG_CRC_POLY : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   crc8_step()  : one bit-serial, MSB-first CRC-8 update step
// ---------------------------------------------------------------------------
package cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } cfg_state_t;

    localparam logic [7:0] CFG_CRC_POLY = 8'h07;

    // Non-reflected, MSB-first update: the incoming bit is XORed with the
    // register MSB and the result decides whether the polynomial is folded in.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CFG_CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// ---------------------------------------------------------------------------
// cfg_chain_loader_if
// Host word stream into the loader (valid/ready handshake).
//   word_data  : bitstream word, MSB is shifted into the chain first
//   word_valid : word_data holds a valid word
//   word_ready : loader takes the word this cycle (transfer on valid && ready)
// Modports:
//   master : host side (drives data/valid, observes ready)
//   slave  : loader side (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface cfg_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/cfg_crc8_serial.sv
// ---------------------------------------------------------------------------
// cfg_crc8_serial
// Bit-serial CRC-8 accumulator (poly 0x07, init 0x00, MSB-first, no xorout).
// Ports:
//   clk    : clock
//   nrst   : asynchronous active-low reset (clears the CRC)
//   clr    : synchronous clear back to the init value
//   step   : absorb bit_in this cycle
//   bit_in : serial data bit
//   crc    : current CRC value
// ---------------------------------------------------------------------------
module cfg_crc8_serial
    import cfg_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       clr,
    input  logic       step,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = 8'h00;
        end else if (step) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// ---------------------------------------------------------------------------
// cfg_chain_loader
// Loads a daisy-chained LE configuration shift chain from a host word stream,
// then recirculates the chain once to restore it while reading it back, and
// compares a CRC-8 of the bits sent against a CRC-8 of the bits returned.
// Ports:
//   clk          : system clock (shared with the LE config registers)
//   nrst         : asynchronous active-low reset
//   en           : global enable; everything freezes and cfg_en=0 while low
//   start        : begin a load (only honoured in IDLE)
//   word_if      : host word stream (slave side of cfg_chain_loader_if)
//   cfg_data_out : serial bit into the chain head
//   cfg_en       : chain shift strobe
//   cfg_data_in  : serial bit from the chain tail
//   busy         : high while loading or verifying
//   done         : one-cycle completion pulse
//   error        : CRC mismatch, held until the next accepted start
// ---------------------------------------------------------------------------
module cfg_chain_loader
    import cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 68,
    parameter int WORD_W    = 8
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
    input  logic                start,
    cfg_chain_loader_if.slave   word_if,
    output logic                cfg_data_out,
    output logic                cfg_en,
    input  logic                cfg_data_in,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BC_W  = $clog2(WORD_W + 1);

    cfg_state_t        state_q;
    logic              busy_q;
    logic              error_q;

    logic [WORD_W-1:0] buf_q,     buf_d;
    logic [BC_W-1:0]   buf_cnt_q, buf_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    logic              buf_empty;
    logic              load_ready;
    logic              word_accept;
    logic              load_shift;
    logic              verify_shift;
    logic              last_bit;
    logic              start_accept;
    logic [CNT_W-1:0]  bits_left;
    logic [BC_W-1:0]   load_cnt;
    logic [7:0]        tx_crc;
    logic [7:0]        rx_crc;
    logic              crc_bad;

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    assign buf_empty    = (buf_cnt_q == '0);
    assign start_accept = (state_q == IDLE) && start && en;
    assign load_ready   = (state_q == LOAD) && buf_empty
                          && (bit_cnt_q < CNT_W'(CHAIN_LEN)) && en;
    assign word_accept  = load_ready && word_if.word_valid;
    assign load_shift   = (state_q == LOAD) && !buf_empty && en;
    assign verify_shift = (state_q == VERIFY) && en;
    assign last_bit     = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));

    // The final word may carry more bits than the chain still needs; only
    // its upper bits_left bits are shifted and the rest drop out unused.
    assign bits_left = CNT_W'(CHAIN_LEN) - bit_cnt_q;
    assign load_cnt  = (bits_left >= CNT_W'(WORD_W)) ? BC_W'(WORD_W) : BC_W'(bits_left);

    assign word_if.word_ready = load_ready;

    // Strobe and data are decoded straight from state/buffer/en so the chain
    // never sees a shift in IDLE or DONE.
    assign cfg_en       = load_shift || verify_shift;
    assign cfg_data_out = load_shift   ? buf_q[WORD_W-1] :
                          verify_shift ? cfg_data_in     : 1'b0;

    // -----------------------------------------------------------------------
    // Word buffer and chain bit counter
    // -----------------------------------------------------------------------
    always_comb begin
        buf_d     = buf_q;
        buf_cnt_d = buf_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (start_accept) begin
            buf_d     = '0;
            buf_cnt_d = '0;
            bit_cnt_d = '0;
        end else if (word_accept) begin
            buf_d     = word_if.word_data;
            buf_cnt_d = load_cnt;
        end else if (load_shift) begin
            buf_d     = {buf_q[WORD_W-2:0], 1'b0};
            buf_cnt_d = buf_cnt_q - 1'b1;
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
        end else if (verify_shift) begin
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            buf_q     <= '0;
            buf_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            buf_q     <= buf_d;
            buf_cnt_q <= buf_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // CRCs: TX absorbs every bit pushed into the head during LOAD, RX absorbs
    // every bit pulled from the tail during VERIFY.
    // -----------------------------------------------------------------------
    cfg_crc8_serial u_tx_crc (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (start_accept),
        .step   (load_shift),
        .bit_in (buf_q[WORD_W-1]),
        .crc    (tx_crc)
    );

    cfg_crc8_serial u_rx_crc (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (start_accept),
        .step   (verify_shift),
        .bit_in (cfg_data_in),
        .crc    (rx_crc)
    );

    // The RX register has not yet absorbed the last returned bit when leaving
    // VERIFY, so fold it in here so error is valid alongside done.
    assign crc_bad = (crc8_step(rx_crc, cfg_data_in) != tx_crc);

    // -----------------------------------------------------------------------
    // FSM with registered busy/error
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_accept) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_shift && last_bit) begin
                        state_q <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (verify_shift && last_bit) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        error_q <= crc_bad;
                    end
                end
                DONE: begin
                    if (en) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign error = error_q;
    // Gated by en so a frozen DONE state defers the pulse instead of stretching it.
    assign done  = (state_q == DONE) && en;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_cfg_chain_loader
// Drives cfg_chain_loader against a behavioural 4 x 17-bit LE chain model and
// checks cycle counts, handshake counts, done/error and final chain contents.
// ---------------------------------------------------------------------------
module tb_cfg_chain_loader;

    localparam int CHAIN_LEN = 68;
    localparam int WORD_W    = 8;
    localparam int NWORDS    = 9;
    localparam int NONE      = 9999;

    logic clk;
    logic nrst;
    logic en;
    logic start;
    logic cfg_data_out;
    logic cfg_en;
    logic cfg_data_in;
    logic busy;
    logic done;
    logic error;
    logic force_tail;

    logic [CHAIN_LEN-1:0] chain_q;
    logic [CHAIN_LEN-1:0] exp_chain;
    logic [WORD_W-1:0]    words [NWORDS];

    int n_checks;
    int n_errors;
    int n_busy;
    int n_cfg;
    int n_done;
    int n_hs;
    logic hs;
    logic err_at_done;
    bit   aborted;

    cfg_chain_loader_if #(.WORD_W(WORD_W)) wif ();

    cfg_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .start        (start),
        .word_if      (wif),
        .cfg_data_out (cfg_data_out),
        .cfg_en       (cfg_en),
        .cfg_data_in  (cfg_data_in),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four 17-bit LE config registers in series behave as one 68-bit shifter;
    // the LEs share nrst with the loader.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            chain_q <= '0;
        end else if (en && cfg_en) begin
            chain_q <= {chain_q[CHAIN_LEN-2:0], cfg_data_out};
        end
    end

    assign cfg_data_in = force_tail ? 1'b1 : chain_q[CHAIN_LEN-1];

    task automatic check(input string tag, input logic [CHAIN_LEN-1:0] got,
                         input logic [CHAIN_LEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then return just after
    // the next rising edge so the caller can change inputs.
    task automatic tick();
        @(negedge clk);
        if (busy) n_busy++;
        if (cfg_en && en) n_cfg++;
        if (done) begin
            n_done++;
            err_at_done = error;
        end
        hs = wif.word_valid && wif.word_ready;
        if (hs) n_hs++;
        @(posedge clk);
        #1;
    endtask

    // Full load: optional valid gap after word 3, two 10-cycle en pauses,
    // two stray start pulses, reset after rst_bits shifts, tail corruption.
    task automatic run_load(input int gap_len, input int en_off0, input int en_off1,
                            input int st0, input int st1, input int rst_bits,
                            input bit corrupt);
        int  widx;
        int  gap_used;
        int  post;
        bit  gap;
        n_busy = 0; n_cfg = 0; n_done = 0; n_hs = 0;
        err_at_done = 1'bx;
        aborted = 1'b0;
        widx = 0; gap_used = 0; post = 0;
        en = 1'b1;
        start = 1'b1;
        wif.word_valid = 1'b0;
        tick();
        start = 1'b0;
        check("err_clr", {67'd0, error}, 68'd0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (rst_bits > 0 && n_cfg == rst_bits) begin
                nrst = 1'b0;
                #1;
                check("rst_busy",  {67'd0, busy},           68'd0);
                check("rst_cfgen", {67'd0, cfg_en},         68'd0);
                check("rst_ready", {67'd0, wif.word_ready}, 68'd0);
                check("rst_dout",  {67'd0, cfg_data_out},   68'd0);
                check("rst_chain", chain_q,                 68'd0);
                nrst = 1'b1;
                wif.word_valid = 1'b0;
                aborted = 1'b1;
                break;
            end
            gap = (gap_len > 0) && (widx == 3) && (n_cfg == 24) && (gap_used < gap_len);
            wif.word_valid = (widx < NWORDS) && !gap;
            wif.word_data  = (widx < NWORDS) ? words[widx] : '0;
            en = !((cyc >= en_off0 && cyc < en_off0 + 10) ||
                   (cyc >= en_off1 && cyc < en_off1 + 10));
            start = (cyc == st0) || (cyc == st1);
            force_tail = corrupt && (n_cfg >= CHAIN_LEN);
            tick();
            if (gap) gap_used++;
            if (hs) widx++;
            if (n_done > 0) post++;
            if (post == 4) break;
        end
        wif.word_valid = 1'b0;
        start = 1'b0;
        en = 1'b1;
        force_tail = 1'b0;
        $display("load: busy=%0d cfg_en=%0d words=%0d done=%0d error=%b reset=%0b",
                 n_busy, n_cfg, n_hs, n_done, err_at_done, aborted);
    endtask

    task automatic check_run(input string tag, input int exp_busy, input bit exp_err,
                             input bit chk_chain);
        check({tag, "_busy"},  68'(n_busy), 68'(exp_busy));
        check({tag, "_cfgen"}, 68'(n_cfg),  68'(2 * CHAIN_LEN));
        check({tag, "_words"}, 68'(n_hs),   68'(NWORDS));
        check({tag, "_done"},  68'(n_done), 68'd1);
        check({tag, "_err"},   {67'd0, err_at_done}, {67'd0, exp_err});
        if (chk_chain) check({tag, "_chain"}, chain_q, exp_chain);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0;
        words[3] = 8'h0F; words[4] = 8'h96; words[5] = 8'h69;
        words[6] = 8'hC3; words[7] = 8'h5A; words[8] = 8'hB7;
        // First bit sent ends up at the tail (MSB of the model).
        for (int i = 0; i < CHAIN_LEN; i++) begin
            exp_chain[CHAIN_LEN-1-i] = words[i/8][7-(i%8)];
        end
        nrst = 1'b0; en = 1'b0; start = 1'b0; force_tail = 1'b0;
        wif.word_valid = 1'b0; wif.word_data = '0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        #1;
        check("reset_ready", {67'd0, wif.word_ready}, 68'd0);
        check("reset_cfgen", {67'd0, cfg_en},         68'd0);
        check("reset_dout",  {67'd0, cfg_data_out},   68'd0);
        check("reset_busy",  {67'd0, busy},           68'd0);
        check("reset_done",  {67'd0, done},           68'd0);
        check("reset_error", {67'd0, error},          68'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // 1: back-to-back stream
        run_load(0, NONE, NONE, NONE, NONE, 0, 1'b0);
        check_run("t1", 145, 1'b0, 1'b1);

        // 3: valid low for 5 cycles between words 3 and 4
        run_load(5, NONE, NONE, NONE, NONE, 0, 1'b0);
        check_run("t3", 150, 1'b0, 1'b1);

        // 4: en low 10 cycles mid-LOAD and 10 mid-VERIFY
        run_load(0, 40, 120, NONE, NONE, 0, 1'b0);
        check_run("t4", 165, 1'b0, 1'b1);

        // 5: reset at LOAD bit 30, then a full reload
        run_load(0, NONE, NONE, NONE, NONE, 30, 1'b0);
        check("t5_aborted", {67'd0, aborted}, 68'd1);
        repeat (2) @(posedge clk);
        #1;
        run_load(0, NONE, NONE, NONE, NONE, 0, 1'b0);
        check_run("t5", 145, 1'b0, 1'b1);

        // 2: tail forced high during VERIFY
        run_load(0, NONE, NONE, NONE, NONE, 0, 1'b1);
        check_run("t2", 145, 1'b1, 1'b0);

        // 6: error holds in IDLE; stray starts in LOAD/VERIFY ignored
        repeat (3) @(posedge clk);
        #1;
        check("t6_err_hold", {67'd0, error}, 68'd1);
        run_load(0, NONE, NONE, 30, 100, 0, 1'b0);
        check_run("t6", 145, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
